// File: rtl/uart_transmitter_if.sv
// Producer-side bundle for the UART transmitter: byte, valid/ready and FIFO occupancy.
// No latency of its own; pure wiring between producer and transmitter.
// Backpressure: producer must hold tx_valid until it sees tx_ready high at a clock edge.
interface uart_transmitter_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) ();
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_valid;
    logic                         tx_ready;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (output tx_data, output tx_valid, input tx_ready, input fifo_count);
    modport slave  (input tx_data, input tx_valid, output tx_ready, output fifo_count);
endinterface

// File: rtl/uart_transmitter.sv
// Small synchronous FIFO with occupancy count; read data is the current head (show-ahead).
// Latency: a write is visible at the head one clock later; pop takes effect at the clock edge.
// Backpressure: wr_rdy drops when count reaches DEPTH; a pop when empty is the caller's bug.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       wr_rdy,
    input  logic                       rd_pop,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;

    assign wr_rdy = (count != CW'(DEPTH));
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    // Storage array: written only on an accepted push, so later tx_data changes never leak in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, rd_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// UART transmit framer: start, LSB-first data, optional parity, 1-2 stop bits, fed from a FIFO.
// Latency: first byte's start bit appears on the next baud_clk_en after the push, +1 clk register.
// Backpressure: tx_ready low while the FIFO is full; frames chain back-to-back with no idle gap.
module uart_transmitter #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk_en,
    uart_transmitter_if.slave    bus,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nx;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        bit_idx_nx;
    logic                 stop_cnt;
    logic                 stop_cnt_nx;
    logic                 par_bit;
    logic                 par_bit_nx;
    logic                 tx_out_nx;
    logic                 tx_done_nx;
    logic                 pop;
    logic                 start_frame;
    logic                 have_byte;
    logic [DATA_BITS-1:0] head;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (bus.tx_valid),
        .wr_dat (bus.tx_data),
        .wr_rdy (bus.tx_ready),
        .rd_pop (pop),
        .rd_dat (head),
        .count  (bus.fifo_count)
    );

    assign have_byte = (bus.fifo_count != '0);

    // Next-state and next-output logic; every transition is qualified by baud_clk_en.
    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_idx_nx  = bit_idx;
        stop_cnt_nx = stop_cnt;
        par_bit_nx  = par_bit;
        tx_out_nx   = tx_out;
        tx_done_nx  = 1'b0;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_out_nx = 1'b1;
                if (baud_clk_en && have_byte) begin
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (baud_clk_en) begin
                    tx_out_nx  = shreg[0];
                    shreg_nx   = shreg >> 1;
                    bit_idx_nx = '0;
                    state_nx   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_clk_en) begin
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx_out_nx = par_bit;
                            state_nx  = ST_PARITY;
                        end else begin
                            tx_out_nx   = 1'b1;
                            stop_cnt_nx = 1'b0;
                            state_nx    = ST_STOP;
                        end
                    end else begin
                        tx_out_nx  = shreg[0];
                        shreg_nx   = shreg >> 1;
                        bit_idx_nx = bit_idx + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_clk_en) begin
                    tx_out_nx   = 1'b1;
                    stop_cnt_nx = 1'b0;
                    state_nx    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_clk_en) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        tx_done_nx = 1'b1;
                        if (have_byte) begin
                            start_frame = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_nx = 1'b1;
                    end
                end
            end
            default: begin
                tx_out_nx = 1'b1;
                state_nx  = ST_IDLE;
            end
        endcase

        // Shared frame launch from IDLE or straight out of the last stop bit.
        if (start_frame) begin
            pop        = 1'b1;
            shreg_nx   = head;
            par_bit_nx = (^head) ^ (PARITY == 2);
            tx_out_nx  = 1'b0;
            state_nx   = ST_START;
        end
    end

    // State and output registers; reset abandons any frame and parks the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_idx  <= bit_idx_nx;
            stop_cnt <= stop_cnt_nx;
            par_bit  <= par_bit_nx;
            tx_out   <= tx_out_nx;
            tx_busy  <= (state_nx != ST_IDLE);
            tx_done  <= tx_done_nx;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 8N1, 8E1, 8O2, back-to-back, FIFO full, push-during-pop, reset.
// Bit periods are 16 clk; every bit is checked on each of its 16 cycles relative to the start edge.
// Outputs are sampled on the falling clock edge, inputs are driven there too.
module tb_uart_transmitter;
    logic clk;
    logic rst_n;
    logic baud_clk_en;
    logic baud_gate;
    int   bcnt;
    int   n_checks;
    int   n_fail;

    logic tx_out0, tx_busy0, tx_done0;
    logic tx_out1, tx_busy1, tx_done1;
    logic tx_out2, tx_busy2, tx_done2;

    uart_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc0 ();
    uart_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc1 ();
    uart_transmitter_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc2 ();

    uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .bus(ifc0),
        .tx_out(tx_out0), .tx_busy(tx_busy0), .tx_done(tx_done0));
    uart_transmitter #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .bus(ifc1),
        .tx_out(tx_out1), .tx_busy(tx_busy1), .tx_done(tx_done1));
    uart_transmitter #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en), .bus(ifc2),
        .tx_out(tx_out2), .tx_busy(tx_busy2), .tx_done(tx_done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud pulse generator: one-cycle pulse every 16 clk while gated on.
    initial begin
        baud_clk_en = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!baud_gate) begin
                bcnt = 0;
                baud_clk_en = 1'b0;
            end else begin
                baud_clk_en = (bcnt == 15);
                bcnt = (bcnt == 15) ? 0 : bcnt + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic line(input int d);
        case (d)
            0: return tx_out0;
            1: return tx_out1;
            default: return tx_out2;
        endcase
    endfunction

    function automatic logic busy(input int d);
        case (d)
            0: return tx_busy0;
            1: return tx_busy1;
            default: return tx_busy2;
        endcase
    endfunction

    function automatic logic done(input int d);
        case (d)
            0: return tx_done0;
            1: return tx_done1;
            default: return tx_done2;
        endcase
    endfunction

    function automatic logic [2:0] cnt(input int d);
        case (d)
            0: return ifc0.fifo_count;
            1: return ifc1.fifo_count;
            default: return ifc2.fifo_count;
        endcase
    endfunction

    task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h, expected %0h", tag, idx, obs, exp);
        end
    endtask

    task automatic gate_off();
        baud_gate = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input int d, input logic [7:0] data);
        case (d)
            0: begin ifc0.tx_valid = 1'b1; ifc0.tx_data = data; end
            1: begin ifc1.tx_valid = 1'b1; ifc1.tx_data = data; end
            default: begin ifc2.tx_valid = 1'b1; ifc2.tx_data = data; end
        endcase
        @(negedge clk);
        ifc0.tx_valid = 1'b0;
        ifc1.tx_valid = 1'b0;
        ifc2.tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int d, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (line(d) === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Checks one frame bit-by-bit from its start edge; optionally pushes inj_dat on the done cycle.
    task automatic check_frame(input int d, input logic [15:0] exp, input int nbits,
                               input bit expect_next, input bit inj, input logic [7:0] inj_dat,
                               input string tag);
        bit found;
        wait_start(d, found);
        check({tag, "_start"}, 0, 16'(found), 16'd1);
        if (!found) return;
        for (int k = 0; k < nbits; k++) begin
            for (int o = 0; o < 16; o++) begin
                if (inj && k == nbits - 1 && o == 15) begin
                    ifc0.tx_valid = 1'b1;
                    ifc0.tx_data  = inj_dat;
                end
                check({tag, "_bit"}, k, 16'(line(d)), 16'(exp[k]));
                check({tag, "_busy"}, k, 16'(busy(d)), 16'd1);
                if (!(k == 0 && o == 0)) check({tag, "_nodone"}, k, 16'(done(d)), 16'd0);
                @(negedge clk);
                if (inj && k == nbits - 1 && o == 15) ifc0.tx_valid = 1'b0;
            end
        end
        check({tag, "_done"}, nbits, 16'(done(d)), 16'd1);
        check({tag, "_busy_end"}, nbits, 16'(busy(d)), 16'(expect_next));
        check({tag, "_line_end"}, nbits, 16'(line(d)), 16'(!expect_next));
        if (!expect_next) begin
            @(negedge clk);
            check({tag, "_done_1cyc"}, nbits, 16'(done(d)), 16'd0);
            check({tag, "_idle_line"}, nbits, 16'(line(d)), 16'd1);
        end
    endtask

    initial begin
        bit found;
        logic [7:0] fill [5];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44; fill[4] = 8'h99;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        baud_gate = 1'b0;
        ifc0.tx_valid = 1'b0; ifc0.tx_data = '0;
        ifc1.tx_valid = 1'b0; ifc1.tx_data = '0;
        ifc2.tx_valid = 1'b0; ifc2.tx_data = '0;
        repeat (3) @(negedge clk);

        // Reset state on all three instances.
        for (int d = 0; d < 3; d++) begin
            check("rst_line", d, 16'(line(d)), 16'd1);
            check("rst_busy", d, 16'(busy(d)), 16'd0);
            check("rst_done", d, 16'(done(d)), 16'd0);
            check("rst_count", d, 16'(cnt(d)), 16'd0);
        end
        check("rst_ready", 0, 16'(ifc0.tx_ready), 16'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 single frame; nothing leaves the line until a baud pulse arrives.
        push(0, 8'h41);
        check("t1_count", 0, 16'(ifc0.fifo_count), 16'd1);
        check("t1_wait_line", 0, 16'(tx_out0), 16'd1);
        check("t1_wait_busy", 0, 16'(tx_busy0), 16'd0);
        baud_gate = 1'b1;
        check_frame(0, {1'b1, 8'h41, 1'b0}, 10, 1'b0, 1'b0, 8'h00, "t1_8n1");
        check("t1_count_end", 0, 16'(ifc0.fifo_count), 16'd0);

        // Even parity, one stop: parity bit 0 for 0x41, 11-bit frame.
        gate_off();
        push(1, 8'h41);
        baud_gate = 1'b1;
        check_frame(1, {1'b1, 1'b0, 8'h41, 1'b0}, 11, 1'b0, 1'b0, 8'h00, "t2_8e1");

        // Odd parity, two stops: parity bit 1, line high two periods before done.
        gate_off();
        push(2, 8'h41);
        baud_gate = 1'b1;
        check_frame(2, {2'b11, 1'b1, 8'h41, 1'b0}, 12, 1'b0, 1'b0, 8'h00, "t2_8o2");

        // Back-to-back: second start bit begins in the done cycle.
        gate_off();
        push(0, 8'h55);
        push(0, 8'hAA);
        check("t3_count", 0, 16'(ifc0.fifo_count), 16'd2);
        baud_gate = 1'b1;
        check_frame(0, {1'b1, 8'h55, 1'b0}, 10, 1'b1, 1'b0, 8'h00, "t3_f55");
        check_frame(0, {1'b1, 8'hAA, 1'b0}, 10, 1'b0, 1'b0, 8'h00, "t3_faa");

        // FIFO full: 5th byte refused, then all four go out in order.
        gate_off();
        ifc0.tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc0.tx_data = fill[i];
            @(negedge clk);
            check("t4_fill_count", i, 16'(ifc0.fifo_count), (i < 4) ? 16'(i + 1) : 16'd4);
            check("t4_fill_ready", i, 16'(ifc0.tx_ready), (i < 3) ? 16'd1 : 16'd0);
        end
        ifc0.tx_valid = 1'b0;
        baud_gate = 1'b1;
        wait_start(0, found);
        check("t4_first_pop", 0, 16'(found), 16'd1);
        check("t4_ready_pop", 0, 16'(ifc0.tx_ready), 16'd1);
        check("t4_count_pop", 0, 16'(ifc0.fifo_count), 16'd3);
        check_frame(0, {1'b1, 8'h11, 1'b0}, 10, 1'b1, 1'b0, 8'h00, "t4_f11");
        check_frame(0, {1'b1, 8'h22, 1'b0}, 10, 1'b1, 1'b0, 8'h00, "t4_f22");
        check_frame(0, {1'b1, 8'h33, 1'b0}, 10, 1'b1, 1'b0, 8'h00, "t4_f33");
        check_frame(0, {1'b1, 8'h44, 1'b0}, 10, 1'b0, 1'b0, 8'h00, "t4_f44");
        check("t4_count_end", 0, 16'(ifc0.fifo_count), 16'd0);

        // Push in the same cycle as the STOP->START pop: count holds, order kept.
        gate_off();
        push(0, 8'h5A);
        push(0, 8'hC3);
        baud_gate = 1'b1;
        check_frame(0, {1'b1, 8'h5A, 1'b0}, 10, 1'b1, 1'b1, 8'h3C, "t5_f5a");
        check("t5_count_same", 0, 16'(ifc0.fifo_count), 16'd1);
        check_frame(0, {1'b1, 8'hC3, 1'b0}, 10, 1'b1, 1'b0, 8'h00, "t5_fc3");
        check_frame(0, {1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0, 8'h00, "t5_f3c");

        // Reset during data bit 3 of 0xF0 (a 0 on the line), with a byte still queued.
        gate_off();
        push(0, 8'hF0);
        push(0, 8'h0F);
        baud_gate = 1'b1;
        wait_start(0, found);
        check("t6_start", 0, 16'(found), 16'd1);
        repeat (72) @(negedge clk);
        check("t6_pre_line", 0, 16'(tx_out0), 16'd0);
        check("t6_pre_count", 0, 16'(ifc0.fifo_count), 16'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_line", 0, 16'(tx_out0), 16'd1);
        check("t6_rst_busy", 0, 16'(tx_busy0), 16'd0);
        check("t6_rst_count", 0, 16'(ifc0.fifo_count), 16'd0);
        check("t6_rst_done", 0, 16'(tx_done0), 16'd0);
        gate_off();
        rst_n = 1'b1;
        baud_gate = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("t6_idle_line", i, 16'(tx_out0), 16'd1);
            check("t6_idle_done", i, 16'(tx_done0), 16'd0);
        end
        push(0, 8'hA5);
        check_frame(0, {1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0, 8'h00, "t6_fa5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
